// File: rtl/aes_xts_pkg.sv
// Shared definitions for the XTS round sequencer: round count, FSM encoding and
// key-set select codes.
package aes_xts_pkg;

   localparam int ROUNDS = 14;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

   localparam logic KEYSEL_DATA = 1'b0;
   localparam logic KEYSEL_TWK  = 1'b1;

endpackage

// File: rtl/aes_xts_round_counter.sv
// Round index counter: clear, load and enable, with a flag raised on the final
// round. It saturates at ROUNDS rather than wrapping.
module aes_xts_round_counter #(
   parameter int ROUNDS = 14,
   parameter int RIDX_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              load,
   input  logic [RIDX_W-1:0] load_val,
   input  logic              en,
   output logic [RIDX_W-1:0] cnt,
   output logic              at_last
);

   localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(ROUNDS);

   logic [RIDX_W-1:0] cnt_d;
   logic [RIDX_W-1:0] cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != LAST_IDX)) begin
         cnt_d = cnt_q + RIDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt     = cnt_q;
   assign at_last = (cnt_q == LAST_IDX);

endmodule

// File: rtl/aes_xts_round_sequencer.sv
// Sequencer for the shared iterative AES-256 core in the XTS path: arbitrates
// tweak/data jobs, steps the round index and tracks tweak validity.
module aes_xts_round_sequencer
   import aes_xts_pkg::*;
#(
   parameter int ROUNDS = aes_xts_pkg::ROUNDS,
   parameter int RIDX_W = 4
) (
   input  logic              inClk,
   input  logic              inRstN,
   input  logic              inKeyReady,
   input  logic              inKeyLoad,
   input  logic              inTwkReq,
   input  logic              inDataReq,
   output logic              outTwkGrant,
   output logic              outDataGrant,
   output logic              outCoreLoad,
   output logic              outCoreRound,
   output logic              outLastRound,
   output logic [RIDX_W-1:0] outRoundIdx,
   output logic              outKeySel,
   output logic              outTwkDone,
   output logic              outDataDone,
   output logic              outTwkMulAlpha,
   output logic              outTwkValid,
   output logic              outBusy
);

   seq_state_e state_d, state_q;
   logic       job_d, job_q;
   logic       twk_valid_d, twk_valid_q;
   logic       key_chg_d, key_chg_q;

   logic              grant_win;
   logic              twk_fresh;
   logic              twk_gnt;
   logic              data_gnt;
   logic              cnt_clr;
   logic              cnt_load;
   logic              cnt_en;
   logic [RIDX_W-1:0] cnt;
   logic              at_last;

   aes_xts_round_counter #(
      .ROUNDS (ROUNDS),
      .RIDX_W (RIDX_W)
   ) u_round_counter (
      .clk      (inClk),
      .rst_n    (inRstN),
      .clr      (cnt_clr),
      .load     (cnt_load),
      .load_val (RIDX_W'(1)),
      .en       (cnt_en),
      .cnt      (cnt),
      .at_last  (at_last)
   );

   // A new job may be granted from IDLE or from the DONE cycle of the previous
   // job, which is what gives back-to-back blocks a 16-cycle spacing. A tweak
   // finishing in this DONE cycle already qualifies a waiting data request.
   always_comb begin
      grant_win = inRstN && inKeyReady && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      twk_fresh = (state_q == ST_DONE) && (job_q == KEYSEL_TWK) && !key_chg_q;
      twk_gnt   = grant_win && inTwkReq;
      data_gnt  = grant_win && !inTwkReq && inDataReq && !inKeyLoad &&
                  (twk_valid_q || twk_fresh);
   end

   always_comb begin
      state_d        = state_q;
      job_d          = job_q;
      twk_valid_d    = twk_valid_q;
      key_chg_d      = key_chg_q;
      cnt_clr        = 1'b0;
      cnt_load       = 1'b0;
      cnt_en         = 1'b0;
      outTwkGrant    = twk_gnt;
      outDataGrant   = data_gnt;
      outCoreLoad    = 1'b0;
      outCoreRound   = 1'b0;
      outLastRound   = 1'b0;
      outRoundIdx    = '0;
      outKeySel      = KEYSEL_DATA;
      outTwkDone     = 1'b0;
      outDataDone    = 1'b0;
      outTwkMulAlpha = 1'b0;
      outBusy        = (state_q != ST_IDLE);

      case (state_q)
         ST_IDLE: begin
            if (twk_gnt || data_gnt) begin
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            outCoreLoad = 1'b1;
            outRoundIdx = cnt;
            outKeySel   = job_q;
            cnt_load    = 1'b1;
            state_d     = ST_RUN;
         end
         ST_RUN: begin
            outCoreRound = 1'b1;
            outLastRound = at_last;
            outRoundIdx  = cnt;
            outKeySel    = job_q;
            cnt_en       = 1'b1;
            if (at_last) begin
               cnt_clr = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            outKeySel      = job_q;
            outTwkDone     = (job_q == KEYSEL_TWK);
            outDataDone    = (job_q == KEYSEL_DATA);
            outTwkMulAlpha = (job_q == KEYSEL_DATA);
            state_d        = (twk_gnt || data_gnt) ? ST_LOAD : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (twk_gnt || data_gnt) begin
         job_d     = twk_gnt ? KEYSEL_TWK : KEYSEL_DATA;
         key_chg_d = 1'b0;
      end
      // A key written while a job is in flight poisons that job's tweak result.
      if (inKeyLoad && ((state_q != ST_IDLE) || twk_gnt || data_gnt)) begin
         key_chg_d = 1'b1;
      end

      if (twk_fresh) begin
         twk_valid_d = 1'b1;
      end
      if (twk_gnt || inKeyLoad) begin
         twk_valid_d = 1'b0;
      end
   end

   always_ff @(posedge inClk or negedge inRstN) begin
      if (!inRstN) begin
         state_q     <= ST_IDLE;
         job_q       <= KEYSEL_DATA;
         twk_valid_q <= 1'b0;
         key_chg_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         job_q       <= job_d;
         twk_valid_q <= twk_valid_d;
         key_chg_q   <= key_chg_d;
      end
   end

   assign outTwkValid = twk_valid_q;

endmodule

// File: tb/tb_aes_xts_round_sequencer.sv
// Directed bench for aes_xts_round_sequencer: a job-offset model checked every
// cycle, plus literal timing expectations for each scenario.
module tb_aes_xts_round_sequencer;

   localparam int RIDX_W = 4;
   localparam int NCYC   = 1024;
   localparam int JOBLEN = 16;

   logic clk = 1'b0;
   logic rst_n, key_ready, key_load, twk_req, data_req;
   logic twk_grant, data_grant, core_load, core_round, last_round;
   logic [RIDX_W-1:0] round_idx;
   logic key_sel, twk_done, data_done, twk_mul, twk_valid, busy;

   aes_xts_round_sequencer #(.ROUNDS(14), .RIDX_W(RIDX_W)) dut (
      .inClk          (clk),
      .inRstN         (rst_n),
      .inKeyReady     (key_ready),
      .inKeyLoad      (key_load),
      .inTwkReq       (twk_req),
      .inDataReq      (data_req),
      .outTwkGrant    (twk_grant),
      .outDataGrant   (data_grant),
      .outCoreLoad    (core_load),
      .outCoreRound   (core_round),
      .outLastRound   (last_round),
      .outRoundIdx    (round_idx),
      .outKeySel      (key_sel),
      .outTwkDone     (twk_done),
      .outDataDone    (data_done),
      .outTwkMulAlpha (twk_mul),
      .outTwkValid    (twk_valid),
      .outBusy        (busy)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   // Model: offset k of the current job since its grant (1 = LOAD .. 16 = DONE).
   int m_active = 0, m_k = 0, m_jt = 0, m_tv = 0, m_kc = 0;

   bit h_tg[NCYC], h_dg[NCYC], h_td[NCYC], h_dd[NCYC], h_mul[NCYC];
   bit h_last[NCYC], h_tv[NCYC], h_busy[NCYC], h_ks[NCYC];
   int h_idx[NCYC];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      int cur, e_idx, tg, dg, fresh, eff_tv;
      @(negedge clk);
      cur = (rst_n && m_active != 0) ? m_k : 0;
      fresh  = (cur == JOBLEN && m_jt == 1 && m_kc == 0) ? 1 : 0;
      eff_tv = (m_tv != 0 || fresh != 0) ? 1 : 0;
      tg = (rst_n && key_ready && (cur == 0 || cur == JOBLEN) && twk_req) ? 1 : 0;
      dg = (rst_n && key_ready && (cur == 0 || cur == JOBLEN) && !twk_req && data_req &&
            eff_tv != 0 && !key_load) ? 1 : 0;
      e_idx = (cur >= 1 && cur <= 15) ? cur - 1 : 0;

      chk("twk_grant",  int'(twk_grant),  tg);
      chk("data_grant", int'(data_grant), dg);
      chk("core_load",  int'(core_load),  (cur == 1) ? 1 : 0);
      chk("core_round", int'(core_round), (cur >= 2 && cur <= 15) ? 1 : 0);
      chk("last_round", int'(last_round), (cur == 15) ? 1 : 0);
      chk("round_idx",  int'(round_idx),  e_idx);
      chk("key_sel",    int'(key_sel),    (cur > 0) ? m_jt : 0);
      chk("twk_done",   int'(twk_done),   (cur == JOBLEN && m_jt == 1) ? 1 : 0);
      chk("data_done",  int'(data_done),  (cur == JOBLEN && m_jt == 0) ? 1 : 0);
      chk("twk_mul",    int'(twk_mul),    (cur == JOBLEN && m_jt == 0) ? 1 : 0);
      chk("twk_valid",  int'(twk_valid),  rst_n ? m_tv : 0);
      chk("busy",       int'(busy),       (cur > 0) ? 1 : 0);

      if (cyc < NCYC) begin
         h_tg[cyc] = twk_grant;  h_dg[cyc] = data_grant; h_td[cyc] = twk_done;
         h_dd[cyc] = data_done;  h_mul[cyc] = twk_mul;   h_last[cyc] = last_round;
         h_tv[cyc] = twk_valid;  h_busy[cyc] = busy;     h_ks[cyc] = key_sel;
         h_idx[cyc] = int'(round_idx);
      end

      if (!rst_n) begin
         m_active = 0; m_k = 0; m_jt = 0; m_tv = 0; m_kc = 0;
      end else begin
         if (fresh != 0) m_tv = 1;
         if (tg != 0 || key_load) m_tv = 0;
         if (tg != 0 || dg != 0) m_kc = 0;
         if (key_load && (cur > 0 || tg != 0 || dg != 0)) m_kc = 1;
         if (tg != 0 || dg != 0) begin
            m_active = 1; m_k = 1; m_jt = tg;
         end else if (m_active != 0) begin
            if (m_k == JOBLEN) m_active = 0;
            else m_k++;
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   initial begin
      int t0, t1, t2, t3, t4, t5, ta, sum;
      rst_n = 1'b0; key_ready = 1'b0; key_load = 1'b0; twk_req = 1'b0; data_req = 1'b0;
      run(3);
      chk("lit_reset_busy", int'(h_busy[1]), 0);
      chk("lit_reset_tvalid", int'(h_tv[2]), 0);

      // Data request without a valid tweak must never be granted.
      rst_n = 1'b1; key_ready = 1'b1; data_req = 1'b1;
      ta = cyc;
      run(50);
      sum = 0;
      for (int i = 0; i < 50; i++) sum += int'(h_dg[ta+i]);
      chk("lit_nodata_grants", sum, 0);
      chk("lit_nodata_busy", int'(h_busy[ta+49]), 0);

      // Single tweak job.
      data_req = 1'b0;
      t0 = cyc; twk_req = 1'b1; step(); twk_req = 1'b0;
      run(19);
      chk("lit_twk_grant", int'(h_tg[t0]), 1);
      chk("lit_twk_idx_first", h_idx[t0+1], 0);
      chk("lit_twk_idx_last", h_idx[t0+15], 14);
      chk("lit_twk_last", int'(h_last[t0+15]), 1);
      chk("lit_twk_keysel", int'(h_ks[t0+8]), 1);
      chk("lit_twk_done", int'(h_td[t0+16]), 1);
      chk("lit_twk_valid_pre", int'(h_tv[t0+16]), 0);
      chk("lit_twk_valid_post", int'(h_tv[t0+17]), 1);

      // Three back-to-back data blocks.
      t1 = cyc; data_req = 1'b1;
      run(33);
      data_req = 1'b0;
      run(18);
      chk("lit_dg0", int'(h_dg[t1]), 1);
      chk("lit_dg1", int'(h_dg[t1+16]), 1);
      chk("lit_dg2", int'(h_dg[t1+32]), 1);
      chk("lit_dg3_none", int'(h_dg[t1+48]), 0);
      chk("lit_dd0", int'(h_dd[t1+16]), 1);
      chk("lit_dd1", int'(h_dd[t1+32]), 1);
      chk("lit_dd2", int'(h_dd[t1+48]), 1);
      chk("lit_mul2", int'(h_mul[t1+48]), 1);
      chk("lit_data_keysel", int'(h_ks[t1+5]), 0);

      // Simultaneous requests: tweak first, data on the tweak's DONE cycle.
      t2 = cyc; twk_req = 1'b1; data_req = 1'b1; step(); twk_req = 1'b0;
      run(16);
      data_req = 1'b0;
      run(20);
      chk("lit_both_tg", int'(h_tg[t2]), 1);
      chk("lit_both_dg_wait", int'(h_dg[t2]), 0);
      chk("lit_both_dg", int'(h_dg[t2+16]), 1);
      chk("lit_both_dd", int'(h_dd[t2+32]), 1);

      // Key load during a tweak job: job completes, tweak stays invalid.
      t3 = cyc; twk_req = 1'b1; step(); twk_req = 1'b0;
      run(5);
      key_load = 1'b1; step(); key_load = 1'b0;
      run(15);
      chk("lit_kl_idx5", h_idx[t3+6], 5);
      chk("lit_kl_done", int'(h_td[t3+16]), 1);
      chk("lit_kl_tvalid", int'(h_tv[t3+17]), 0);
      data_req = 1'b1; ta = cyc;
      run(5);
      data_req = 1'b0;
      sum = 0;
      for (int i = 0; i < 5; i++) sum += int'(h_dg[ta+i]);
      chk("lit_kl_no_data", sum, 0);

      // Restore a valid tweak, then reset in the middle of a data job.
      t4 = cyc; twk_req = 1'b1; step(); twk_req = 1'b0;
      run(17);
      chk("lit_retwk_valid", int'(h_tv[t4+17]), 1);
      t5 = cyc; data_req = 1'b1; step(); data_req = 1'b0;
      run(7);
      rst_n = 1'b0;
      run(2);
      rst_n = 1'b1;
      run(20);
      chk("lit_rst_dg", int'(h_dg[t5]), 1);
      chk("lit_rst_idx6", h_idx[t5+7], 6);
      chk("lit_rst_busy", int'(h_busy[t5+8]), 0);
      chk("lit_rst_idx", h_idx[t5+8], 0);
      sum = 0;
      for (int i = 0; i < 30; i++) sum += int'(h_dd[t5+i]);
      chk("lit_rst_no_done", sum, 0);
      chk("lit_rst_tvalid", int'(h_tv[t5+29]), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
